alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-drive signals shared between the pipeline, the arbiter and the ALU.
// The arbiter connects through the slave modport; the requesters/ALU side uses master.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;

    logic              resp0_valid, resp1_valid;
    logic              resp0_ready, resp1_ready;
    logic [DATA_W-1:0] resp0_result, resp1_result;
    logic              resp0_zero, resp1_zero;
    logic              resp0_err, resp1_err;

    logic [DATA_W-1:0] alu_a, alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_ctrl, req1_ctrl,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp0_result, resp1_result,
        output resp0_zero, resp1_zero, resp0_err, resp1_err,
        input  resp0_ready, resp1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_ctrl, req1_ctrl,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp0_result, resp1_result,
        input  resp0_zero, resp1_zero, resp0_err, resp1_err,
        output resp0_ready, resp1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 win every tie (fixed priority).
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              pick;
    logic [CTRL_W-1:0] sel_ctrl;

    function automatic logic op_legal(input logic [CTRL_W-1:0] op);
        logic ok;
        case (op)
            CTRL_W'(4'b0000), CTRL_W'(4'b0001), CTRL_W'(4'b0010), CTRL_W'(4'b0100),
            CTRL_W'(4'b1000), CTRL_W'(4'b1001), CTRL_W'(4'b1010): ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick = bus.req0_valid ? 1'b0 : 1'b1;
`else
        if (bus.req0_valid && bus.req1_valid)
            pick = ~last_grant_q;
        else
            pick = bus.req1_valid;
`endif
        sel_ctrl = pick ? bus.req1_ctrl : bus.req0_ctrl;
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        illegal_d    = illegal_q;
        result_d     = result_q;
        zero_d       = zero_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    a_d          = pick ? bus.req1_a : bus.req0_a;
                    b_d          = pick ? bus.req1_b : bus.req0_b;
                    ctrl_d       = sel_ctrl;
                    illegal_d    = !op_legal(sel_ctrl);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // An illegal op never reaches the ALU, so its flags are forced rather than captured.
                result_d = illegal_q ? '0 : bus.alu_result;
                zero_d   = !illegal_q && bus.alu_zero;
                err_d    = illegal_q;
                state_d  = RESP;
            end
            RESP: begin
                if (gnt_q ? bus.resp1_ready : bus.resp0_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            illegal_q    <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            illegal_q    <= illegal_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    // Handshake outputs decode only the state register.
    always_comb begin
        bus.req0_ready   = (state_q == IDLE);
        bus.req1_ready   = (state_q == IDLE);
        bus.resp0_valid  = (state_q == RESP) && !gnt_q;
        bus.resp1_valid  = (state_q == RESP) && gnt_q;
        bus.resp0_result = result_q;
        bus.resp1_result = result_q;
        bus.resp0_zero   = zero_q;
        bus.resp1_zero   = zero_q;
        bus.resp0_err    = err_q;
        bus.resp1_err    = err_q;
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        bus.alu_ctrl     = '0;
        if (state_q == EXEC && !illegal_q) begin
            bus.alu_a    = a_q;
            bus.alu_b    = b_q;
            bus.alu_ctrl = ctrl_q;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(32), .CTRL_W(4)) bus ();

    alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb begin
        case (bus.alu_ctrl)
            4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0100: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b1000: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'b1001: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            4'b1010: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            default: bus.alu_result = 32'h0;
        endcase
        bus.alu_zero = (bus.alu_result == 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req0_ready"}, 32'(bus.req0_ready), 32'd1);
        chk({tag, ".req1_ready"}, 32'(bus.req1_ready), 32'd1);
        chk({tag, ".resp0_valid"}, 32'(bus.resp0_valid), 32'd0);
        chk({tag, ".resp1_valid"}, 32'(bus.resp1_valid), 32'd0);
        chk({tag, ".result"}, bus.resp0_result, 32'd0);
        chk({tag, ".zero"}, 32'(bus.resp0_zero), 32'd0);
        chk({tag, ".err"}, 32'(bus.resp0_err), 32'd0);
        chk({tag, ".alu_a"}, bus.alu_a, 32'd0);
        chk({tag, ".alu_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
    endtask

    // Bounded wait for either response; port is -1 on timeout.
    task automatic wait_resp(output int port);
        port = -1;
        for (int i = 0; i < 8; i++) begin
            if (bus.resp0_valid) begin port = 0; break; end
            if (bus.resp1_valid) begin port = 1; break; end
            tick();
        end
    endtask

    initial begin
        int port;
        int n0;
        int n1;
        logic [1:0] exp_gnt [4];

        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req0_ctrl = 0;
        bus.req1_a = 0; bus.req1_b = 0; bus.req1_ctrl = 0;
        bus.resp0_ready = 0; bus.resp1_ready = 0;

        // Reset
        tick(); tick();
        rst_n = 1;
        tick();
        chk_reset_outputs("reset");

        // Port 0 ADD 5,7 alone
        bus.req0_valid = 1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_ctrl = 4'b0000;
        tick();
        bus.req0_valid = 0;
        chk("add.exec_ready", 32'(bus.req0_ready), 32'd0);
        chk("add.exec_alu_a", bus.alu_a, 32'd5);
        chk("add.exec_alu_b", bus.alu_b, 32'd7);
        chk("add.exec_no_resp", 32'(bus.resp0_valid), 32'd0);
        tick();
        chk("add.resp0_valid", 32'(bus.resp0_valid), 32'd1);
        chk("add.resp1_valid", 32'(bus.resp1_valid), 32'd0);
        chk("add.result", bus.resp0_result, 32'd12);
        chk("add.zero", 32'(bus.resp0_zero), 32'd0);
        chk("add.err", 32'(bus.resp0_err), 32'd0);
        chk("add.alu_idle", bus.alu_a, 32'd0);
        bus.resp0_ready = 1;
        tick();
        chk("add.done_valid", 32'(bus.resp0_valid), 32'd0);
        chk("add.done_ready", 32'(bus.req0_ready), 32'd1);

        // Both valid from reset: port 0 first, then port 1
        rst_n = 0; tick(); rst_n = 1;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        bus.req0_valid = 1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_ctrl = 4'b0001;
        bus.req1_valid = 1; bus.req1_a = 32'hF0F0_0000; bus.req1_b = 32'h0F0F_0000; bus.req1_ctrl = 4'b1000;
        tick();
        bus.req0_valid = 0;
        tick();
        chk("tie.first_resp0", 32'(bus.resp0_valid), 32'd1);
        chk("tie.first_result", bus.resp0_result, 32'd0);
        chk("tie.first_zero", 32'(bus.resp0_zero), 32'd1);
        tick();
        tick();
        bus.req1_valid = 0;
        tick();
        chk("tie.second_resp1", 32'(bus.resp1_valid), 32'd1);
        chk("tie.second_resp0", 32'(bus.resp0_valid), 32'd0);
        chk("tie.second_result", bus.resp1_result, 32'hFFFF_0000);
        chk("tie.second_zero", 32'(bus.resp1_zero), 32'd0);
        tick();

        // Four back-to-back pairs
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_gnt = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_gnt = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        bus.req0_valid = 1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_ctrl = 4'b0000;
        bus.req1_valid = 1; bus.req1_a = 32'd2; bus.req1_b = 32'd2; bus.req1_ctrl = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_resp(port);
            chk($sformatf("rr.grant%0d", k), 32'(port), 32'(exp_gnt[k]));
            chk($sformatf("rr.result%0d", k), bus.resp0_result, exp_gnt[k] == 2'd0 ? 32'd2 : 32'd4);
            tick();
        end

        // Twelve cycles with both ports valid continuously
        n0 = 0; n1 = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.resp0_valid) n0++;
            if (bus.resp1_valid) n1++;
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("cont.port0_count", 32'(n0), 32'd4);
        chk("cont.port1_count", 32'(n1), 32'd0);
`else
        chk("cont.port0_count", 32'(n0), 32'd2);
        chk("cont.port1_count", 32'(n1), 32'd2);
`endif
        bus.req0_valid = 0; bus.req1_valid = 0;
        for (int c = 0; c < 4; c++) tick();

        // Port 1 SLL with response back-pressure
        bus.resp0_ready = 0; bus.resp1_ready = 0;
        bus.req1_valid = 1; bus.req1_a = 32'd1; bus.req1_b = 32'd4; bus.req1_ctrl = 4'b1010;
        tick();
        bus.req1_valid = 0;
        bus.req0_valid = 1; bus.req0_a = 32'd3; bus.req0_b = 32'd3; bus.req0_ctrl = 4'b0000;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall.valid%0d", c), 32'(bus.resp1_valid), 32'd1);
            chk($sformatf("stall.result%0d", c), bus.resp1_result, 32'd16);
            chk($sformatf("stall.ready%0d", c), {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            if (c < 4) tick();
        end
        bus.resp1_ready = 1;
        tick();
        bus.req0_valid = 0;
        chk("stall.released", 32'(bus.resp1_valid), 32'd0);
        chk("stall.ready_back", 32'(bus.req0_ready), 32'd1);
        bus.resp1_ready = 0;

        // Illegal op then a legal OR
        bus.req0_valid = 1; bus.req0_a = 32'd5; bus.req0_b = 32'd6; bus.req0_ctrl = 4'b0011;
        tick();
        bus.req0_valid = 0;
        chk("illegal.alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("illegal.alu_a", bus.alu_a, 32'd0);
        tick();
        chk("illegal.valid", 32'(bus.resp0_valid), 32'd1);
        chk("illegal.err", 32'(bus.resp0_err), 32'd1);
        chk("illegal.result", bus.resp0_result, 32'd0);
        chk("illegal.zero", 32'(bus.resp0_zero), 32'd0);
        bus.resp0_ready = 1;
        tick();
        bus.req0_valid = 1; bus.req0_a = 32'd3; bus.req0_b = 32'd4; bus.req0_ctrl = 4'b0100;
        tick();
        bus.req0_valid = 0;
        chk("or.alu_ctrl", 32'(bus.alu_ctrl), 32'd4);
        tick();
        chk("or.valid", 32'(bus.resp0_valid), 32'd1);
        chk("or.result", bus.resp0_result, 32'd7);
        chk("or.err", 32'(bus.resp0_err), 32'd0);
        tick();

        // Reset while in EXEC drops the transaction
        bus.req0_valid = 1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_ctrl = 4'b0000;
        tick();
        bus.req0_valid = 0;
        chk("rst_exec.in_exec", bus.alu_a, 32'd1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk_reset_outputs("rst_exec");
        n0 = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.resp0_valid || bus.resp1_valid) n0++;
        end
        chk("rst_exec.no_resp", 32'(n0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
